// File: rtl/scalar_product_stream.sv
// Streaming dot product: skewed multiply-add chain of LANES stages plus a cross-beat accumulator.
// Optional SCALAR_PRODUCT_SAT_EN: saturating accumulator with sticky overflow reported on out_ovf.

module scalar_product_lane #(
  parameter int NBITS = 8,
  parameter int PW    = 18,
  parameter int DLY   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             vld,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [PW-1:0]    psum_in,
  output logic [PW-1:0]    psum_out
);
  logic [NBITS-1:0]   a_d, b_d;
  logic [2*NBITS-1:0] prod;

  // Skew lane operands so they meet their beat's partial sum at this stage
  if (DLY == 0) begin : g_nodly
    assign a_d = a;
    assign b_d = b;
  end else begin : g_dly
    logic [DLY-1:0][NBITS-1:0] a_sr, b_sr;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a_sr <= '0;
        b_sr <= '0;
      end else if (en) begin
        a_sr[0] <= a;
        b_sr[0] <= b;
        for (int j = 1; j < DLY; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
        end
      end
    end
    assign a_d = a_sr[DLY-1];
    assign b_d = b_sr[DLY-1];
  end

  assign prod = {{NBITS{1'b0}}, a_d} * {{NBITS{1'b0}}, b_d};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  psum_out <= '0;
    else if (en) psum_out <= vld ? psum_in + PW'(prod) : '0;
  end
endmodule

module scalar_product_stream #(
  parameter int NBITS = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 2*NBITS+8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*NBITS-1:0] A,
  input  logic [LANES*NBITS-1:0] B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out,
  output logic                   out_ovf
);
  localparam int PW = 2*NBITS + $clog2(LANES);

  logic                        stall, en;
  logic [LANES-1:0][NBITS-1:0] a_q, b_q;
  logic [LANES:0]              vld_pipe, lst_pipe;
  logic [PW-1:0]               psum [LANES+1];
  logic [ACC_W-1:0]            acc, acc_nxt;
  logic [ACC_W:0]              acc_sum;
  logic                        ovf, ovf_nxt;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;
  assign psum[0]  = '0;

  // Index 0 is the input capture register; index k follows chain stage k
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else if (en) begin
      a_q      <= A;
      b_q      <= B;
      vld_pipe <= {vld_pipe[LANES-1:0], in_valid};
      lst_pipe <= {lst_pipe[LANES-1:0], in_last};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    scalar_product_lane #(.NBITS(NBITS), .PW(PW), .DLY(k)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .vld      (vld_pipe[k]),
      .a        (a_q[k]),
      .b        (b_q[k]),
      .psum_in  (psum[k]),
      .psum_out (psum[k+1])
    );
  end

  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(psum[LANES]);

`ifdef SCALAR_PRODUCT_SAT_EN
  // Once saturated, acc stays at all-ones: any further add carries out again
  always_comb begin
    ovf_nxt = ovf | acc_sum[ACC_W];
    acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    ovf_nxt = 1'b0;
    acc_nxt = acc_sum[ACC_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (vld_pipe[LANES] && lst_pipe[LANES]) begin
        out       <= acc_nxt;
        out_ovf   <= ovf_nxt;
        out_valid <= 1'b1;
        acc       <= '0;
        ovf       <= 1'b0;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (vld_pipe[LANES]) begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_scalar_product_stream.sv
// Scoreboard bench for scalar_product_stream (LANES=4, NBITS=8, ACC_W=18).
module tb_scalar_product_stream;
  localparam int NBITS = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 18;
  localparam longint AMAX = (64'd1 << ACC_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid, in_ready, in_last;
  logic [LANES*NBITS-1:0] A, B;
  logic                   out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0]       out;

  scalar_product_stream #(.NBITS(NBITS), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { longint v; logic o; } exp_t;
  exp_t   sb[$];
  longint acc_m;
  logic   ovf_m;
  int     n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [7:0] b0, b1, b2, b3;
    b0 = a0[7:0]; b1 = a1[7:0]; b2 = a2[7:0]; b3 = a3[7:0];
    return {b3, b2, b1, b0};
  endfunction

  // Reference model: scoreboard fed on accepted beats, drained on output handshakes
  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) begin
        longint s, t;
        exp_t   e;
        s = 0;
        for (int i = 0; i < LANES; i++) s += longint'(A[i*NBITS +: NBITS]) * longint'(B[i*NBITS +: NBITS]);
        t = acc_m + s;
`ifdef SCALAR_PRODUCT_SAT_EN
        if (t > AMAX) begin t = AMAX; ovf_m = 1'b1; end
`else
        t = t & AMAX;
`endif
        if (in_last) begin
          e.v = t; e.o = ovf_m;
          sb.push_back(e);
          acc_m = 0; ovf_m = 1'b0;
        end else acc_m = t;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_out", out, e.v);
          chk("sb_ovf", out_ovf, e.o);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int w;
    in_valid = 1'b1; A = a; B = b; in_last = last; w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, run;
    logic [ACC_W-1:0] held;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; A = '0; B = '0; out_ready = 1'b1;
    acc_m = 0; ovf_m = 1'b0;
    idle(3);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b1;
    idle(2);

    // Single beat, latency and one-cycle pulse
    send(pk(1,2,3,4), pk(5,6,7,8), 1'b1);
    wait_out(cyc);
    chk("lat", cyc, 5);
    chk("t1_out", out, 70);
    idle(1);
    chk("t1_pulse", out_valid, 0);

    // Two-beat vector: no output after beat1
    send(pk(255,255,255,255), pk(255,255,255,255), 1'b0);
    send(pk(1,1,1,1), pk(1,1,1,1), 1'b1);
    wait_out(cyc);
    chk("t2_out", out, 260104);
    idle(8);

    // Back-to-back single-beat vectors on consecutive cycles
    fork
      for (int k = 1; k <= 8; k++) send(pk(k,k,k,k), pk(k,k,k,k), 1'b1);
      begin
        wait_out(cyc);
        run = 0;
        while (out_valid && run < 20) begin run++; @(posedge clk); #1; end
        chk("b2b_run", run, 8);
      end
    join
    idle(5);

    // Back-pressure: freeze while results pending
    out_ready = 1'b0;
    fork
      for (int k = 9; k <= 16; k++) send(pk(k,k,k,k), pk(k,k,k,k), 1'b1);
      begin
        wait_out(cyc);
        held = out;
        repeat (6) begin
          @(posedge clk); #1;
          chk("stall_out", out, held);
          chk("stall_valid", out_valid, 1);
          chk("stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(15);

    // Reset mid-vector discards partial data
    send(pk(255,255,255,255), pk(255,255,255,255), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_valid", out_valid, 0);
    acc_m = 0; ovf_m = 1'b0; sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    send(pk(1,2,3,4), pk(5,6,7,8), 1'b1);
    wait_out(cyc);
    chk("post_rst_out", out, 70);
    idle(3);

    // Accumulator overflow
    send(pk(255,255,255,255), pk(255,255,255,255), 1'b0);
    send(pk(255,255,255,255), pk(255,255,255,255), 1'b1);
    wait_out(cyc);
`ifdef SCALAR_PRODUCT_SAT_EN
    chk("ovf_out", out, 262143);
    chk("ovf_flag", out_ovf, 1);
`else
    chk("ovf_out", out, 258056);
    chk("ovf_flag", out_ovf, 0);
`endif
    idle(10);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/scalar_product_stream.md
Name: scalar_product_stream

Overview:
- Parametrised successor of the 4-lane pipelined scalar product.
- Computes dot products of arbitrarily long vectors streamed as LANES-element beats.
- Uses a skewed multiply-add chain of LANES stages followed by a cross-beat accumulator.
- Has valid/ready handshakes and end-of-vector tagging; sits between the matrix-row feeders and the result collector in the matmul datapath.

Parameters:
- NBITS, 8, unsigned element width
- LANES, 4, elements per beat (>=1); also the number of chain stages
- ACC_W, 2*NBITS+8, accumulator/result width; must be >= 2*NBITS+clog2(LANES)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  beat is final beat of current vector
- A  in  LANES*NBITS  lane i = A[(i+1)*NBITS-1 : i*NBITS]
- B  in  LANES*NBITS  same packing as A
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out  out  ACC_W  dot product of completed vector
- out_ovf  out  1  accumulator overflowed for this vector (feature-dependent)

Behaviour:
- Reset low: all pipeline, delay, valid/last shift registers, accumulator and outputs clear immediately. out=0, out_valid=0, out_ovf=0. Any partial vector is discarded.
- stall = out_valid && !out_ready. in_ready = !stall (combinational).
- On stall, every register holds: delays, stage sums, valid/last tags, accumulator, outputs.
- Lane i operands are delayed i cycles before stage i+1 (lane 0 undelayed).
- Stage k registers psum_k = psum_{k-1} + a*b, unsigned. psum width = 2*NBITS+clog2(LANES); no intermediate overflow.
- A valid bit and a last bit travel with each beat through the stages.
- Bubbles (valid=0) propagate as zeros and never touch the accumulator.
- Accumulate stage, on a valid beat leaving stage LANES with sum s:
  - not last: acc <= acc + s
  - last: out <= acc + s, out_valid <= 1, acc <= 0
- Latency: a beat accepted at edge t produces its result at edge t+LANES+1, assuming no stalls.
- Throughput: one beat per cycle; single-beat vectors yield one result per cycle.
- out_valid drops after a handshake unless a new result is written in the same cycle. A pending output is never overwritten, because stall freezes the pipeline.
- Unconsumed partial vectors persist across idle cycles indefinitely.

Optional Feature:
- Macro: SCALAR_PRODUCT_SAT_EN.
- Defined:
  - acc+s saturates at 2^ACC_W-1, and the saturated value is held for the rest of the vector.
  - A sticky overflow bit is set and copied to out_ovf with the result, then cleared with acc.
- Undefined:
  - acc+s wraps modulo 2^ACC_W.
  - out_ovf is tied to 0.

Test Plan:
- LANES=4: A lanes {1,2,3,4}, B lanes {5,6,7,8}, in_last=1, out_ready=1 -> out=70, out_valid high exactly one cycle, 5 cycles after acceptance.
- Two-beat vector: beat1 all lanes 255*255, beat2 (last) all lanes 1*1 -> single result 260104; no output after beat1.
- Eight back-to-back single-beat vectors with A=B lanes all = k, for k=1..8 -> results 4*k*k (4,16,…,256) on consecutive cycles, in order.
- out_ready=0 for 6 cycles while results pending, in_valid kept high -> in_ready=0, out stable, pipeline frozen. After release, every result appears exactly once with correct values.
- Reset pulsed after beat1 of a two-beat vector -> out/out_valid go to 0 immediately. The next single-beat vector {1,2,3,4}·{5,6,7,8} yields 70, not contaminated by pre-reset data.
- ACC_W=18, two-beat vector, each beat all lanes 255*255 (sum 260100):
  - SAT defined -> out=262143, out_ovf=1
  - SAT undefined -> out=258056, out_ovf=0
